// File: rtl/mem_responder.sv
// Responder for the core's fetch and load/store traffic. It serialises both onto a
// single-port backing memory and strobes pc_enable once each instruction completes.
module mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_address,
    input  logic [31:0] data_address,
    input  logic        dm_read_en,
    input  logic        dm_write_en,
    input  logic        store_byte,
    input  logic [31:0] data_to_write,
    output logic [31:0] instruction_read,
    output logic [31:0] data_read,
    output logic        pc_enable,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_error
);

    localparam logic [32:0] BYTE_LIMIT = 33'(MEM_WORDS) << 2;
    localparam logic [7:0]  WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FETCH_WAIT,
        S_DECODE,
        S_DATA,
        S_DATA_WAIT,
        S_COMMIT
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] dread_reg, dread_next;
    logic        pc_enable_reg, pc_enable_next;
    logic        req_reg, req_next;
    logic        we_reg, we_next;
    logic [29:0] addr_reg, addr_next;
    logic [3:0]  be_reg, be_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        bus_error_reg, bus_error_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic        is_write_reg, is_write_next;

    logic fetch_fault;
    logic data_fault;
    logic acked;
    logic timed_out;

    assign fetch_fault = {1'b0, instruction_address} >= BYTE_LIMIT;
    assign data_fault  = {1'b0, data_address} >= BYTE_LIMIT;
    // An ack only counts while a request is actually outstanding.
    assign acked       = req_reg && mem_ack;
    assign timed_out   = req_reg && !mem_ack && (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        state_next     = state_reg;
        instr_next     = instr_reg;
        dread_next     = dread_reg;
        pc_enable_next = 1'b0;
        req_next       = req_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        be_next        = be_reg;
        wdata_next     = wdata_reg;
        bus_error_next = 1'b0;
        wait_cnt_next  = wait_cnt_reg;
        is_write_next  = is_write_reg;

        case (state_reg)
            S_FETCH: begin
                if (fetch_fault) begin
                    instr_next     = NOP_INST;
                    bus_error_next = 1'b1;
                    state_next     = S_DECODE;
                end else begin
                    req_next      = 1'b1;
                    we_next       = 1'b0;
                    be_next       = 4'b1111;
                    addr_next     = instruction_address[31:2];
                    wait_cnt_next = 8'd0;
                    state_next    = S_FETCH_WAIT;
                end
            end
            S_FETCH_WAIT: begin
                if (acked) begin
                    instr_next = mem_rdata;
                    req_next   = 1'b0;
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    instr_next     = NOP_INST;
                    req_next       = 1'b0;
                    bus_error_next = 1'b1;
                    state_next     = S_DECODE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            S_DECODE: begin
                if (dm_write_en) begin
                    is_write_next = 1'b1;
                    state_next    = S_DATA;
                end else if (dm_read_en) begin
                    is_write_next = 1'b0;
                    state_next    = S_DATA;
                end else begin
                    pc_enable_next = 1'b1;
                    state_next     = S_COMMIT;
                end
            end
            S_DATA: begin
                if (data_fault) begin
                    if (!is_write_reg) begin
                        dread_next = 32'd0;
                    end
                    bus_error_next = 1'b1;
                    pc_enable_next = 1'b1;
                    state_next     = S_COMMIT;
                end else begin
                    req_next      = 1'b1;
                    we_next       = is_write_reg;
                    addr_next     = data_address[31:2];
                    wait_cnt_next = 8'd0;
                    // Byte stores replicate the byte so any lane can pick it up.
                    if (is_write_reg && store_byte) begin
                        be_next    = 4'b0001 << data_address[1:0];
                        wdata_next = {4{data_to_write[7:0]}};
                    end else begin
                        be_next    = 4'b1111;
                        wdata_next = data_to_write;
                    end
                    state_next = S_DATA_WAIT;
                end
            end
            S_DATA_WAIT: begin
                if (acked) begin
                    if (!is_write_reg) begin
                        dread_next = mem_rdata;
                    end
                    req_next       = 1'b0;
                    pc_enable_next = 1'b1;
                    state_next     = S_COMMIT;
                end else if (timed_out) begin
                    if (!is_write_reg) begin
                        dread_next = 32'd0;
                    end
                    req_next       = 1'b0;
                    bus_error_next = 1'b1;
                    pc_enable_next = 1'b1;
                    state_next     = S_COMMIT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            S_COMMIT: begin
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_FETCH;
            instr_reg     <= NOP_INST;
            dread_reg     <= 32'd0;
            pc_enable_reg <= 1'b0;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= 30'd0;
            be_reg        <= 4'd0;
            wdata_reg     <= 32'd0;
            bus_error_reg <= 1'b0;
            wait_cnt_reg  <= 8'd0;
            is_write_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            instr_reg     <= instr_next;
            dread_reg     <= dread_next;
            pc_enable_reg <= pc_enable_next;
            req_reg       <= req_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            be_reg        <= be_next;
            wdata_reg     <= wdata_next;
            bus_error_reg <= bus_error_next;
            wait_cnt_reg  <= wait_cnt_next;
            is_write_reg  <= is_write_next;
        end
    end

    assign instruction_read = instr_reg;
    assign data_read        = dread_reg;
    assign pc_enable        = pc_enable_reg;
    assign mem_req          = req_reg;
    assign mem_we           = we_reg;
    assign mem_addr         = addr_reg;
    assign mem_be           = be_reg;
    assign mem_wdata        = wdata_reg;
    assign bus_error        = bus_error_reg;

endmodule
